spram_be_clr: RTL and testbench
===============================

Name: spram_be_clr

Overview:
Parametrised simple-dual-port synchronous RAM that replaces the single-port spram generation. It has independent read and write addresses, per-byte write enables, a selectable read latency and a selectable read-during-write policy. An optional reset-triggered clear sequencer walks the whole array and writes a fixed value to every word. It is used for SNES WRAM/VRAM/CGRAM-style stores on the zxtres target, where the contents must be deterministic after a core reset.

Parameters:
addr_width, 8, address bits for both ports
data_width, 8, word width; must be an integer multiple of byte_width
byte_width, 8, lane width controlled by one byteena bit
NUMWORDS, 1<<addr_width, implemented depth; must be <= 2^addr_width
RD_LATENCY, 1, read latency in cycles, 1 or 2
RDW_MODE, 0, same-address read-during-write result: 0 = old data, 1 = new (merged) data
CLEAR_ON_RESET, 1, 1 = run the clear sequence after reset, 0 = no clear (array keeps its contents)
CLEAR_VALUE, 0, data_width value written to every word by the clear sequence

Ports:
clock  in  1  single clock; all logic on the rising edge
reset  in  1  asynchronous, active-high reset
rdaddress  in  addr_width  read address
rden  in  1  read request
wraddress  in  addr_width  write address
data  in  data_width  write data
wren  in  1  write request
byteena  in  data_width/byte_width  per-lane write enable; bit i covers data[i*byte_width +: byte_width]
q  out  data_width  read data
q_valid  out  1  pulses high for the cycle in which q carries the result of an accepted read
busy  out  1  clear sequence in progress; both ports are blocked while high

Behaviour:
- One clock and one reset, as already decided. reset is asynchronous and active-high.
- Reset values: q=0, q_valid=0, busy=CLEAR_ON_RESET, clear counter=0, read pipeline stages=0, FSM=CLEAR if CLEAR_ON_RESET else IDLE. Reset does not alter array contents.
- Clear FSM states and transitions:
  - CLEAR: on each rising edge after reset deasserts, write CLEAR_VALUE to address cnt (all lanes), then cnt+1. When cnt == NUMWORDS-1, the write for that word occurs and the FSM moves to IDLE.
  - busy is high for exactly NUMWORDS cycles after reset deassert and is low from the following edge.
  - IDLE: terminal state until the next reset.
  - Reset asserted during CLEAR: counter returns to 0 and the sequence restarts from address 0 after deassert.
- While busy:
  - wren and rden are ignored; no user write lands.
  - q_valid stays 0 and q holds its value.
- Write (not busy): at the edge where wren=1 and wraddress < NUMWORDS, lanes with byteena[i]=1 take data; the other lanes keep their old contents.
  - byteena all zero: no change.
  - wraddress >= NUMWORDS: write dropped.
- Read (not busy):
  - rden=1 is accepted at edge N.
  - RD_LATENCY=1: q and q_valid=1 update at edge N, i.e. visible in cycle N+1.
  - RD_LATENCY=2: one extra output register; visible in cycle N+2.
  - q_valid is a one-cycle pulse per accepted read. Back-to-back reads stream one result per cycle.
  - q holds its last value when no read completes.
  - rdaddress >= NUMWORDS returns 0 with q_valid=1.
- Read-during-write (rden and wren at the same edge, rdaddress == wraddress):
  - RDW_MODE=0: q returns the pre-write word.
  - RDW_MODE=1: q returns the merged word (new lanes where byteena=1, old lanes elsewhere).
  - Different addresses: independent, no interaction.
- Pipeline on reset: reset asserted with reads in flight discards them; no q_valid is produced for those reads.
- Array contents on power-up: initialised to CLEAR_VALUE for simulation. No file load.

Test Plan:
- NUMWORDS=256, CLEAR_ON_RESET=1, CLEAR_VALUE=0xA5: release reset -> busy high exactly 256 cycles. Then reading addresses 0, 127, 255 -> q=0xA5 each, q_valid one pulse per read.
- data_width=16, byte_width=8: write 0x1234 to addr 3 (byteena=11), then write 0xABCD with byteena=01 -> read addr 3 returns 0x12CD.
- RDW_MODE=0 vs 1: addr 5 holds 0x11. Issue a simultaneous write 0x22 and read of addr 5 -> q=0x11 (mode 0) / 0x22 (mode 1). A read of addr 5 on the next cycle returns 0x22 in both modes.
- RD_LATENCY=2: rden on edges 10, 11, 12 at addrs 0, 1, 2 (preloaded 0x01, 0x02, 0x03) -> q_valid high in cycles 12–14 with q=0x01, 0x02, 0x03.
- Reset asserted at clear cycle 100 of 256 -> after deassert busy lasts a full 256 cycles. Any wren during busy (addr 7, 0x55) -> addr 7 reads CLEAR_VALUE afterwards.
- Reset asserted with two reads in flight (RD_LATENCY=2) -> q=0 and q_valid=0 immediately. No stray q_valid pulse after deassert.

Source files
------------

// File: rtl/spram_be_clr.sv
// Simple-dual-port synchronous RAM with per-byte write enables and a selectable read latency.
// An optional sequencer fills the array with CLEAR_VALUE after every reset; both ports stay blocked until it finishes.
module spram_be_clr #(
    parameter int addr_width = 8,
    parameter int data_width = 8,
    parameter int byte_width = 8,
    parameter int NUMWORDS = 1 << addr_width,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE = 0,
    parameter int CLEAR_ON_RESET = 1,
    parameter logic [data_width-1:0] CLEAR_VALUE = '0
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [addr_width-1:0]            rdaddress,
    input  logic                             rden,
    input  logic [addr_width-1:0]            wraddress,
    input  logic [data_width-1:0]            data,
    input  logic                             wren,
    input  logic [data_width/byte_width-1:0] byteena,
    output logic [data_width-1:0]            q,
    output logic                             q_valid,
    output logic                             busy
);
    localparam int LANES = data_width / byte_width;
    localparam logic [addr_width:0] DEPTH = (addr_width + 1)'(NUMWORDS);
    localparam logic [addr_width-1:0] LAST = addr_width'(NUMWORDS - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                state, state_nxt;
    logic [addr_width-1:0] cnt;
    logic                  clr_we;
    logic [data_width-1:0] mem [NUMWORDS] = '{default: CLEAR_VALUE};

    logic                  wr_in_range, rd_in_range, wr_ok, rd_ok;
    logic [data_width-1:0] wr_old, wr_merged, rd_old, rd_word;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (clr_we)
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == CLEAR && cnt == LAST)
            state_nxt = IDLE;
    end

    always_comb begin
        busy   = (state == CLEAR);
        clr_we = (state == CLEAR);
    end

    always_comb begin
        wr_in_range = ({1'b0, wraddress} < DEPTH);
        rd_in_range = ({1'b0, rdaddress} < DEPTH);
        wr_ok       = wren && !busy && wr_in_range;
        rd_ok       = rden && !busy;
        wr_old      = wr_in_range ? mem[wraddress] : '0;
        rd_old      = rd_in_range ? mem[rdaddress] : '0;
        wr_merged   = wr_old;
        for (int i = 0; i < LANES; i++) begin
            if (byteena[i])
                wr_merged[i*byte_width +: byte_width] = data[i*byte_width +: byte_width];
        end
        // Mode 1 forwards the merged word; mode 0 keeps the array's pre-write value.
        rd_word = rd_old;
        if (RDW_MODE != 0 && wr_ok && rd_in_range && wraddress == rdaddress)
            rd_word = wr_merged;
    end

    always_ff @(posedge clock) begin
        if (clr_we)
            mem[cnt] <= CLEAR_VALUE;
        else if (wr_ok)
            mem[wraddress] <= wr_merged;
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic [data_width-1:0] q_p0;
            logic                  vld_p0;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    q_p0    <= '0;
                    vld_p0  <= 1'b0;
                    q       <= '0;
                    q_valid <= 1'b0;
                end else begin
                    vld_p0 <= rd_ok;
                    if (rd_ok)
                        q_p0 <= rd_word;
                    // stage p0 -> output register
                    q_valid <= vld_p0;
                    if (vld_p0)
                        q <= q_p0;
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    q       <= '0;
                    q_valid <= 1'b0;
                end else begin
                    q_valid <= rd_ok;
                    if (rd_ok)
                        q <= rd_word;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_spram_be_clr.sv
// Randomised bench for spram_be_clr: two instances (latency 1 / old-data, latency 2 / new-data, short depth)
// share stimulus and are compared every cycle against an array-and-queue reference model.
module tb_spram_be_clr;
    localparam logic [15:0] CLR = 16'h00A5;
    localparam int NW   [2] = '{256, 200};
    localparam int LAT  [2] = '{1, 2};
    localparam int MODE [2] = '{0, 1};

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rdaddress = '0, wraddress = '0;
    logic        rden = 1'b0, wren = 1'b0;
    logic [15:0] data = '0;
    logic [1:0]  byteena = '0;
    logic [15:0] q0, q1;
    logic        qv0, qv1, busy0, busy1;

    int checks = 0;
    int errors = 0;

    typedef struct { int k; logic [15:0] val; int due; } rd_t;
    rd_t         pq[$];
    logic [15:0] mem [2][256];
    int          busy_left [2];
    logic [15:0] exp_q [2];
    logic        exp_v [2];
    int          e = 0;

    always #5 clock = ~clock;

    spram_be_clr #(
        .addr_width(8), .data_width(16), .byte_width(8), .NUMWORDS(256),
        .RD_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CLR)
    ) dut0 (
        .clock(clock), .reset(reset), .rdaddress(rdaddress), .rden(rden),
        .wraddress(wraddress), .data(data), .wren(wren), .byteena(byteena),
        .q(q0), .q_valid(qv0), .busy(busy0)
    );

    spram_be_clr #(
        .addr_width(8), .data_width(16), .byte_width(8), .NUMWORDS(200),
        .RD_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CLR)
    ) dut1 (
        .clock(clock), .reset(reset), .rdaddress(rdaddress), .rden(rden),
        .wraddress(wraddress), .data(data), .wren(wren), .byteena(byteena),
        .q(q1), .q_valid(qv1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %h want %h", tag, e, obs, exp);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] d, input logic [1:0] be);
        merge = o;
        if (be[0]) merge[7:0]  = d[7:0];
        if (be[1]) merge[15:8] = d[15:8];
    endfunction

    task automatic check_now();
        chk("busy0", {31'b0, busy0}, {31'b0, busy_left[0] > 0});
        chk("qv0",   {31'b0, qv0},   {31'b0, exp_v[0]});
        chk("q0",    {16'b0, q0},    {16'b0, exp_q[0]});
        chk("busy1", {31'b0, busy1}, {31'b0, busy_left[1] > 0});
        chk("qv1",   {31'b0, qv1},   {31'b0, exp_v[1]});
        chk("q1",    {16'b0, q1},    {16'b0, exp_q[1]});
    endtask

    // Reset throws away in-flight reads, zeroes q and restarts the fill.
    task automatic reset_model();
        pq.delete();
        for (int k = 0; k < 2; k++) begin
            exp_q[k] = '0;
            exp_v[k] = 1'b0;
            busy_left[k] = NW[k];
        end
    endtask

    task automatic model_edge();
        rd_t         keep[$];
        logic [15:0] old, val;
        e++;
        exp_v[0] = 1'b0;
        exp_v[1] = 1'b0;
        if (reset) return;
        for (int k = 0; k < 2; k++) begin
            if (busy_left[k] > 0) begin
                mem[k][NW[k] - busy_left[k]] = CLR;
                busy_left[k]--;
            end else begin
                old = (int'(rdaddress) < NW[k]) ? mem[k][rdaddress] : 16'h0000;
                if (rden) begin
                    val = old;
                    if (MODE[k] == 1 && wren && wraddress == rdaddress && int'(rdaddress) < NW[k])
                        val = merge(old, data, byteena);
                    pq.push_back('{k: k, val: val, due: e + LAT[k] - 1});
                end
                if (wren && int'(wraddress) < NW[k])
                    mem[k][wraddress] = merge(mem[k][wraddress], data, byteena);
            end
        end
        foreach (pq[i]) begin
            if (pq[i].due == e) begin
                exp_q[pq[i].k] = pq[i].val;
                exp_v[pq[i].k] = 1'b1;
            end else begin
                keep.push_back(pq[i]);
            end
        end
        pq = keep;
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        check_now();
    endtask

    task automatic cyc(input logic r, input logic [7:0] ra, input logic w, input logic [7:0] wa,
                       input logic [15:0] d, input logic [1:0] be);
        rden = r; rdaddress = ra; wren = w; wraddress = wa; data = d; byteena = be;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'd0, 1'b0, 8'd0, 16'h0, 2'b00);
    endtask

    initial begin
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 256; a++) mem[k][a] = CLR;
        #2 reset = 1'b1;
        #1 reset_model();
        check_now();
        idle(3);
        reset = 1'b0;
        idle(258);

        cyc(1, 8'd0, 0, 0, 0, 0);
        cyc(1, 8'd127, 0, 0, 0, 0);
        cyc(1, 8'd255, 0, 0, 0, 0);
        idle(2);

        cyc(0, 0, 1, 8'd3, 16'h1234, 2'b11);
        cyc(0, 0, 1, 8'd3, 16'hABCD, 2'b01);
        cyc(1, 8'd3, 0, 0, 0, 0);
        idle(2);

        cyc(0, 0, 1, 8'd5, 16'h0011, 2'b11);
        cyc(1, 8'd5, 1, 8'd5, 16'h0022, 2'b11);
        cyc(1, 8'd5, 0, 0, 0, 0);
        idle(2);

        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 8'(i), 16'(i + 1), 2'b11);
        for (int i = 0; i < 3; i++) cyc(1, 8'(i), 0, 0, 0, 0);
        idle(3);

        cyc(0, 0, 1, 8'd220, 16'h7777, 2'b11);
        cyc(1, 8'd220, 0, 0, 0, 0);
        cyc(1, 8'd210, 1, 8'd210, 16'h3C3C, 2'b10);
        cyc(0, 0, 1, 8'd9, 16'hFFFF, 2'b00);
        cyc(1, 8'd9, 0, 0, 0, 0);
        idle(2);

        for (int i = 0; i < 1500; i++) begin
            logic [7:0] ra, wa;
            ra = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            wa = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            cyc(1'($urandom), ra, 1'($urandom), wa, 16'($urandom), 2'($urandom));
        end

        cyc(1, 8'd1, 0, 0, 0, 0);
        cyc(1, 8'd2, 0, 0, 0, 0);
        reset = 1'b1;
        #1 reset_model();
        check_now();
        idle(2);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) cyc(1'($urandom), 8'd7, 1, 8'd7, 16'h0055, 2'b11);
        reset = 1'b1;
        #1 reset_model();
        check_now();
        idle(2);
        reset = 1'b0;
        for (int i = 0; i < 258; i++) cyc(1'($urandom), 8'd7, 1, 8'd7, 16'h0055, 2'b11);
        idle(1);
        cyc(1, 8'd7, 0, 0, 0, 0);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
